// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 refresh sequencer: command codes,
// the init command ROM, state encodings and the digit-to-ASCII mapping.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] SET_DDRAM     = 8'h80;

    localparam int         INIT_LEN  = 6;
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    // Top-level sequencer states
    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_IDLE  = 3'd4
    } lcd_state_e;

    // Write-strobe phases
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SETUP = 3'd1,
        PH_PULSE = 3'd2,
        PH_HOLD  = 3'd3,
        PH_GAP   = 3'd4
    } strobe_phase_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic [2:0] gap;
    } init_entry_t;

    // Init command ROM: command byte plus extra settle cycles after HOLD.
    // The longer gaps follow the first function-set and the clear command,
    // which the controller needs more time to execute.
    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = '{cmd: FUNC_SET_8B2L, gap: 3'd5};
            3'd1:    e = '{cmd: FUNC_SET_8B2L, gap: 3'd1};
            3'd2:    e = '{cmd: FUNC_SET_8B2L, gap: 3'd1};
            3'd3:    e = '{cmd: DISP_ON,       gap: 3'd1};
            3'd4:    e = '{cmd: CLEAR,         gap: 3'd2};
            default: e = '{cmd: ENTRY_INC,     gap: 3'd1};
        endcase
        return e;
    endfunction

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] d);
        if (d < 4'd10) begin
            return 8'h30 + {4'h0, d};
        end
        return 8'h37 + {4'h0, d};
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: SETUP (RS/DB valid, E=0), PULSE (E=1), HOLD (E=0),
// then gap_i extra cycles with RS/DB still held.
//
// Handshake: start_i is sampled on every rising edge; the caller raises it
// only while the engine is idle or while done_o is high. done_o is high for
// exactly the last cycle of a write (HOLD when gap is 0, else the final GAP
// cycle), so a start issued in that cycle puts the next SETUP on the very
// next edge with no dead cycle in between.
module lcd_write_strobe
    import lcd_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          rs_i,
    input  logic [7:0]    db_i,
    input  logic [2:0]    gap_i,
    output logic          e_o,
    output logic          rs_o,
    output logic [7:0]    db_o,
    output logic          done_o,
    output strobe_phase_e phase_o
);

    strobe_phase_e phase_q;
    logic [2:0]    gap_q;
    logic [2:0]    gcnt_q;
    logic          e_q;
    logic          rs_q;
    logic [7:0]    db_q;

    // Phase sequencing and registered pin drivers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_IDLE;
            gap_q   <= 3'd0;
            gcnt_q  <= 3'd0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
        end else if (start_i) begin
            phase_q <= PH_SETUP;
            gap_q   <= gap_i;
            gcnt_q  <= 3'd0;
            e_q     <= 1'b0;
            rs_q    <= rs_i;
            db_q    <= db_i;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_q <= PH_PULSE;
                    e_q     <= 1'b1;
                end
                PH_PULSE: begin
                    phase_q <= PH_HOLD;
                    e_q     <= 1'b0;
                end
                PH_HOLD: begin
                    if (gap_q == 3'd0) begin
                        phase_q <= PH_IDLE;
                        rs_q    <= 1'b0;
                    end else begin
                        phase_q <= PH_GAP;
                        gcnt_q  <= 3'd1;
                    end
                end
                PH_GAP: begin
                    if (gcnt_q == gap_q) begin
                        phase_q <= PH_IDLE;
                        rs_q    <= 1'b0;
                    end else begin
                        gcnt_q <= gcnt_q + 3'd1;
                    end
                end
                default: begin
                    phase_q <= PH_IDLE;
                end
            endcase
        end
    end

    assign done_o  = ((phase_q == PH_HOLD) && (gap_q == 3'd0)) ||
                     ((phase_q == PH_GAP) && (gcnt_q == gap_q));
    assign e_o     = e_q;
    assign rs_o    = rs_q;
    assign db_o    = db_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// HD44780 sequencer for the 4-digit counter display: power-up wait, 8-bit
// init commands, then an endless loop of DDRAM address + four digit writes
// separated by an idle refresh interval. All bus timing lives in
// lcd_write_strobe; this level only picks what to write next.
module lcd_refresh_sequencer
    import lcd_pkg::*;
#(
    parameter int         POWERUP_MS = 20,
    parameter int         REFRESH_MS = 50,
    parameter logic [6:0] COL        = 7'h00
) (
    input  logic          clk_1ms,
    input  logic          reset,
    input  logic [3:0]    count0,
    input  logic [3:0]    count1,
    input  logic [3:0]    count2,
    input  logic [3:0]    count3,
    output logic          E_out,
    output logic          RW_out,
    output logic          RS_out,
    output logic [7:0]    DB_out,
    output logic          init_done,
    output logic          frame_done,
    output lcd_state_e    dbg_state,
    output strobe_phase_e dbg_phase
);

    localparam logic [15:0] PWR_END  = 16'(POWERUP_MS);
    localparam logic [15:0] IDLE_END = 16'(REFRESH_MS - 1);
    localparam logic [7:0]  ADDR_CMD = SET_DDRAM | {1'b0, COL};

    lcd_state_e  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [15:0] snap_q;
    logic        init_done_q;
    logic        frame_done_q;

    logic        wr_start;
    logic        wr_rs;
    logic [7:0]  wr_db;
    logic [2:0]  wr_gap;
    logic        wr_done;
    init_entry_t rom_first;
    init_entry_t rom_next;

    // Digit n of the snapshot, leftmost (count3) first
    function automatic logic [3:0] pick_digit(input logic [15:0] s, input logic [1:0] n);
        case (n)
            2'd0:    return s[15:12];
            2'd1:    return s[11:8];
            2'd2:    return s[7:4];
            default: return s[3:0];
        endcase
    endfunction

    // Choose the next write and when to launch it
    always_comb begin
        wr_start  = 1'b0;
        wr_rs     = 1'b0;
        wr_db     = 8'h00;
        wr_gap    = 3'd0;
        rom_first = init_rom(3'd0);
        rom_next  = init_rom(idx_q + 3'd1);
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_END) begin
                    wr_start = 1'b1;
                    wr_db    = rom_first.cmd;
                    wr_gap   = rom_first.gap;
                end
            end
            S_INIT: begin
                if (wr_done) begin
                    wr_start = 1'b1;
                    if (idx_q == INIT_LAST) begin
                        wr_db = ADDR_CMD;
                    end else begin
                        wr_db  = rom_next.cmd;
                        wr_gap = rom_next.gap;
                    end
                end
            end
            S_ADDR: begin
                if (wr_done) begin
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_db    = nibble_to_ascii(pick_digit(snap_q, 2'd0));
                end
            end
            S_DATA: begin
                if (wr_done && (idx_q[1:0] != 2'd3)) begin
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_db    = nibble_to_ascii(pick_digit(snap_q, idx_q[1:0] + 2'd1));
                end
            end
            S_IDLE: begin
                if (cnt_q == IDLE_END) begin
                    wr_start = 1'b1;
                    wr_db    = ADDR_CMD;
                end
            end
            default: begin
                wr_start = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; the digit snapshot is taken on the edge that launches ADDR
    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q      <= S_PWRUP;
            cnt_q        <= 16'd0;
            idx_q        <= 3'd0;
            snap_q       <= 16'h0000;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_PWRUP: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (wr_start) begin
                        state_q <= S_INIT;
                        idx_q   <= 3'd0;
                        cnt_q   <= 16'd0;
                    end
                end
                S_INIT: begin
                    if (wr_done) begin
                        if (idx_q == INIT_LAST) begin
                            state_q     <= S_ADDR;
                            init_done_q <= 1'b1;
                            snap_q      <= {count3, count2, count1, count0};
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (wr_done) begin
                        state_q <= S_DATA;
                        idx_q   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (wr_done) begin
                        if (idx_q[1:0] == 2'd3) begin
                            state_q      <= S_IDLE;
                            cnt_q        <= 16'd0;
                            frame_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_IDLE: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (wr_start) begin
                        state_q <= S_ADDR;
                        cnt_q   <= 16'd0;
                        snap_q  <= {count3, count2, count1, count0};
                    end
                end
                default: begin
                    state_q <= S_PWRUP;
                end
            endcase
        end
    end

    lcd_write_strobe u_strobe (
        .clk_i   (clk_1ms),
        .rst_ni  (reset),
        .start_i (wr_start),
        .rs_i    (wr_rs),
        .db_i    (wr_db),
        .gap_i   (wr_gap),
        .e_o     (E_out),
        .rs_o    (RS_out),
        .db_o    (DB_out),
        .done_o  (wr_done),
        .phase_o (dbg_phase)
    );

    assign RW_out     = 1'b0;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Bench for lcd_refresh_sequencer: a driver schedules frames from the
// documented timing formulas and pushes the expected bus writes, a monitor
// captures each write at the E falling edge and checks it against the queue.
module tb_lcd_refresh_sequencer;
    import lcd_pkg::*;

    localparam int         P          = 20;
    localparam int         R          = 50;
    localparam logic [6:0] COL        = 7'h00;
    localparam int         FRAME      = 15 + R;
    localparam int         FIRST_ADDR = P + 30;

    typedef struct packed {
        logic        rs;
        logic [7:0]  db;
        logic [31:0] edge_n;
    } wr_t;

    // ---------------- clock / reset ----------------
    logic clk_1ms = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_1ms = ~clk_1ms;

    // cyc = number of rising edges since reset release (edge 1 = first)
    int cyc = 0;
    always @(posedge clk_1ms or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [3:0]    count0 = 4'd0, count1 = 4'd0, count2 = 4'd0, count3 = 4'd0;
    logic          E_out, RW_out, RS_out, init_done, frame_done;
    logic [7:0]    DB_out;
    lcd_state_e    dbg_state;
    strobe_phase_e dbg_phase;

    lcd_refresh_sequencer #(
        .POWERUP_MS (P),
        .REFRESH_MS (R),
        .COL        (COL)
    ) dut (
        .clk_1ms    (clk_1ms),
        .reset      (reset),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3),
        .E_out      (E_out),
        .RW_out     (RW_out),
        .RS_out     (RS_out),
        .DB_out     (DB_out),
        .init_done  (init_done),
        .frame_done (frame_done),
        .dbg_state  (dbg_state),
        .dbg_phase  (dbg_phase)
    );

    // ---------------- scoreboard state ----------------
    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    int   fd_q[$];
    int   exp_init_edge = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t cyc=%0d)", name, act, req, $time, cyc);
        end
    endtask

    // Reference digit encoding
    function automatic logic [7:0] ascii_of(input logic [3:0] d);
        int v;
        v = int'(d);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + (v - 10));
    endfunction

    task automatic push_wr(input logic rs, input logic [7:0] db, input int e);
        wr_t w;
        w.rs     = rs;
        w.db     = db;
        w.edge_n = 32'(e);
        exp_q.push_back(w);
    endtask

    // Init writes: E falls 2 edges after SETUP; each write spans 3 + gap edges
    task automatic push_init();
        logic [7:0] cmds [6];
        int         gaps [6];
        int         e;
        cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        gaps = '{5, 1, 1, 1, 2, 1};
        e = P + 3;
        for (int i = 0; i < 6; i++) begin
            push_wr(1'b0, cmds[i], e);
            e = e + 3 + gaps[i];
        end
        exp_init_edge = P + 30;
    endtask

    // Frame whose ADDR SETUP is on edge s, using the inputs present at edge s
    task automatic push_frame(input int s);
        logic [3:0] d [4];
        d = '{count3, count2, count1, count0};
        push_wr(1'b0, 8'h80 | {1'b0, COL}, s + 2);
        for (int k = 0; k < 4; k++) push_wr(1'b1, ascii_of(d[k]), s + 5 + 3 * k);
        fd_q.push_back(s + 15);
    endtask

    function automatic int frame_start(input int f);
        return FIRST_ADDR + f * FRAME;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int target);
        while (cyc < target) @(negedge clk_1ms);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_e"},          int'(E_out),      0);
        chk({tag, "_rw"},         int'(RW_out),     0);
        chk({tag, "_rs"},         int'(RS_out),     0);
        chk({tag, "_db"},         int'(DB_out),     0);
        chk({tag, "_init_done"},  int'(init_done),  0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_1ms);
        check_reset_vals("reset");
        push_init();
        reset = 1'b1;
    endtask

    task automatic randomize_counts();
        count0 = 4'($urandom_range(0, 15));
        count1 = 4'($urandom_range(0, 15));
        count2 = 4'($urandom_range(0, 15));
        count3 = 4'($urandom_range(0, 15));
    endtask

    // ---------------- monitor ----------------
    logic       prev_e    = 1'b0;
    logic       prev_rs   = 1'b0;
    logic [7:0] prev_db   = 8'h00;
    logic       prev_init = 1'b0;
    bit         rise_seen = 1'b0;

    always @(negedge clk_1ms) begin
        if (!reset) begin
            prev_e    = 1'b0;
            prev_rs   = 1'b0;
            prev_db   = 8'h00;
            prev_init = 1'b0;
            rise_seen = 1'b0;
        end else begin
            chk("rw_low", int'(RW_out), 0);
            if (E_out && prev_e) chk("e_high_two_cycles", int'(E_out && prev_e), 0);
            if (E_out != prev_e) begin
                chk("rs_stable_at_e_edge", int'(RS_out), int'(prev_rs));
                chk("db_stable_at_e_edge", int'(DB_out), int'(prev_db));
            end
            if (E_out && !prev_e && !rise_seen) begin
                rise_seen = 1'b1;
                chk("first_e_rise_edge", cyc, P + 2);
                chk("first_e_rise_db", int'(DB_out), 8'h38);
                chk("first_e_rise_rs", int'(RS_out), 0);
            end
            if (!E_out && prev_e) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_db", int'(DB_out), -1);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("write_db",       int'(DB_out), int'(w.db));
                    chk("write_rs",       int'(RS_out), int'(w.rs));
                    chk("write_fall_edge", cyc,          int'(w.edge_n));
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) chk("unexpected_frame_done", cyc, -1);
                else                  chk("frame_done_edge", cyc, fd_q.pop_front());
            end
            if (init_done && !prev_init) chk("init_done_rise_edge", cyc, exp_init_edge);
            if (!init_done && prev_init) chk("init_done_dropped", int'(init_done), 1);
            prev_e    = E_out;
            prev_rs   = RS_out;
            prev_db   = DB_out;
            prev_init = init_done;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        #1;
        do_reset();

        // Session 1: directed frames, then random ones, then reset mid-pulse
        for (int f = 0; f < 7; f++) begin
            s = frame_start(f);
            wait_neg(s - 1);
            case (f)
                0: begin count3 = 4'd1; count2 = 4'd2; count1 = 4'd3; count0 = 4'd15; end
                1: begin count3 = 4'd1; count2 = 4'd2; count1 = 4'd3; count0 = 4'd4;  end
                2: ;
                default: randomize_counts();
            endcase
            push_frame(s);
            if (f == 1) begin
                wait_neg(s);
                count0 = 4'd7;
            end else if (f >= 3) begin
                wait_neg(s + 3);
                randomize_counts();
            end
        end

        s = frame_start(7);
        wait_neg(s - 1);
        randomize_counts();
        push_frame(s);
        wait_neg(s + 7);
        chk("e_high_before_reset", int'(E_out), 1);
        #2 reset = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        fd_q.delete();
        @(negedge clk_1ms);
        do_reset();

        // Session 2: power-up and init must repeat in full
        for (int f = 0; f < 3; f++) begin
            s = frame_start(f);
            wait_neg(s - 1);
            randomize_counts();
            push_frame(s);
            wait_neg(s + 4);
            randomize_counts();
        end
        wait_neg(frame_start(2) + 20);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("frame_done_q_drained", fd_q.size(), 0);
        chk("init_done_final", int'(init_done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=%0t required<200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
